// File: rtl/dma_pkg.sv
// Shared types for the DMA scheduler: FSM states, transfer kinds and a channel
// one-hot helper.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCHED,
    S_ISSUE,
    S_WAIT,
    S_RESUME
  } dma_state_e;

  typedef enum logic [1:0] {
    KIND_GDMA = 2'b00,
    KIND_INIT = 2'b01,
    KIND_LINE = 2'b10
  } xfer_kind_e;

  function automatic logic [7:0] ch_bit(input logic [2:0] ch);
    return 8'b1 << ch;
  endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// Lowest-index-first priority encoder over eight request lines.
module dma_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] index
);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    valid = |req;
    index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/dma_scheduler.sv
// DMA scheduler: halts the CPU at an instruction boundary and sequences HDMA
// init, HDMA line and GDMA channel transfers one at a time.
module dma_scheduler
  import dma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       cpu_boundary,
  input  logic       gdma_we,
  input  logic [7:0] gdma_mask,
  input  logic [7:0] hdma_en,
  input  logic       hdma_init_req,
  input  logic       hdma_line_req,
  input  logic [7:0] hdma_alive,
  output logic       xfer_start,
  output logic [2:0] xfer_ch,
  output logic [1:0] xfer_kind,
  input  logic       xfer_done,
  output logic       cpu_halt,
  output logic [7:0] gdma_pending,
  output logic       busy
);

  dma_state_e state_q, state_d;
  xfer_kind_e kind_q, kind_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] serviced_q, serviced_d;
  logic       init_q, init_d;
  logic       line_q, line_d;
  logic       again_q, again_d;
  logic [7:0] clear_pend;
  logic       end_line_pass;
  logic       line_pass_active;
  logic [7:0] init_cand, line_cand, gdma_cand, sel_req;
  logic       sel_valid;
  logic [2:0] sel_idx;

  // Channels owned by HDMA are never offered to GDMA.
  always_comb begin
    init_cand = hdma_en & ~serviced_q;
    line_cand = hdma_en & hdma_alive & ~serviced_q;
    gdma_cand = pend_q & ~hdma_en;
    if (init_q)      sel_req = init_cand;
    else if (line_q) sel_req = line_cand;
    else             sel_req = gdma_cand;
  end

  dma_prio_enc u_prio (
    .req   (sel_req),
    .valid (sel_valid),
    .index (sel_idx)
  );

  assign line_pass_active = line_q && !init_q &&
                            ((|serviced_q) ||
                             ((state_q == S_ISSUE || state_q == S_WAIT) && kind_q == KIND_LINE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    ch_d          = ch_q;
    serviced_d    = serviced_q;
    init_d        = init_q;
    line_d        = line_q;
    again_d       = again_q;
    clear_pend    = 8'h00;
    end_line_pass = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_en && cpu_boundary && (init_q || line_q || (|pend_q))) state_d = S_SCHED;
      end
      S_SCHED: begin
        if (cpu_en) begin
          if (sel_valid) begin
            ch_d    = sel_idx;
            kind_d  = init_q ? KIND_INIT : (line_q ? KIND_LINE : KIND_GDMA);
            state_d = S_ISSUE;
          end else if (init_q) begin
            init_d     = 1'b0;
            serviced_d = 8'h00;
          end else if (line_q) begin
            end_line_pass = 1'b1;
          end else begin
            state_d = S_RESUME;
          end
        end
      end
      S_ISSUE: begin
        if (cpu_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cpu_en && xfer_done) begin
          state_d = S_SCHED;
          // A completion from a pass that was restarted meanwhile must not mark the new pass.
          if (kind_q == KIND_GDMA) begin
            clear_pend = ch_bit(ch_q);
          end else if (kind_q == KIND_INIT && init_q) begin
            serviced_d = serviced_q | ch_bit(ch_q);
            if ((hdma_en & ~serviced_d) == 8'h00) begin
              init_d     = 1'b0;
              serviced_d = 8'h00;
            end
          end else if (kind_q == KIND_LINE && line_q && !init_q) begin
            serviced_d = serviced_q | ch_bit(ch_q);
            if ((hdma_en & hdma_alive & ~serviced_d) == 8'h00) end_line_pass = 1'b1;
          end
        end
      end
      S_RESUME: begin
        if (cpu_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A line request that arrived mid-pass turns the pass end into a fresh pass.
    if (end_line_pass) begin
      serviced_d = 8'h00;
      if (again_q) again_d = 1'b0;
      else         line_d  = 1'b0;
    end

    pend_d = (pend_q & ~clear_pend) | (gdma_we ? gdma_mask : 8'h00);
    if (hdma_line_req) begin
      if (line_pass_active) again_d = 1'b1;
      line_d = 1'b1;
    end
    if (hdma_init_req) begin
      init_d     = 1'b1;
      line_d     = 1'b0;
      again_d    = 1'b0;
      serviced_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q     <= KIND_GDMA;
      ch_q       <= 3'd0;
      pend_q     <= 8'h00;
      serviced_q <= 8'h00;
      init_q     <= 1'b0;
      line_q     <= 1'b0;
      again_q    <= 1'b0;
    end else begin
      kind_q     <= kind_d;
      ch_q       <= ch_d;
      pend_q     <= pend_d;
      serviced_q <= serviced_d;
      init_q     <= init_d;
      line_q     <= line_d;
      again_q    <= again_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign cpu_halt     = busy;
  assign xfer_start   = (state_q == S_ISSUE) && cpu_en;
  assign xfer_ch      = ch_q;
  assign xfer_kind    = kind_q;
  assign gdma_pending = pend_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// Scenario bench for dma_scheduler: expected transfers are queued when requests
// are raised and compared as each xfer_start appears.
module tb_dma_scheduler;

  logic       clk = 1'b0;
  logic       reset, cpu_en, cpu_boundary, gdma_we;
  logic [7:0] gdma_mask, hdma_en, hdma_alive;
  logic       hdma_init_req, hdma_line_req, xfer_done;
  logic       xfer_start, cpu_halt, busy;
  logic [2:0] xfer_ch;
  logic [1:0] xfer_kind;
  logic [7:0] gdma_pending;

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] kind;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  dma_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .cpu_boundary  (cpu_boundary),
    .gdma_we       (gdma_we),
    .gdma_mask     (gdma_mask),
    .hdma_en       (hdma_en),
    .hdma_init_req (hdma_init_req),
    .hdma_line_req (hdma_line_req),
    .hdma_alive    (hdma_alive),
    .xfer_start    (xfer_start),
    .xfer_ch       (xfer_ch),
    .xfer_kind     (xfer_kind),
    .xfer_done     (xfer_done),
    .cpu_halt      (cpu_halt),
    .gdma_pending  (gdma_pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic next_xfer(output bit found, output xfer_t got);
    found = 1'b0;
    got   = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (xfer_start) begin
        found = 1'b1;
        got   = {xfer_ch, xfer_kind};
      end
    end
  endtask

  function automatic xfer_t pop_exp();
    if (exp_q.size() == 0) return xfer_t'(5'b11111);
    return exp_q.pop_front();
  endfunction

  task automatic pulse_done(input int lat);
    repeat (lat) @(posedge clk);
    #1 xfer_done = 1'b1;
    @(posedge clk);
    #1 xfer_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_en = 1'b1; cpu_boundary = 1'b0; gdma_we = 1'b0; gdma_mask = 8'h00;
    hdma_en = 8'h00; hdma_alive = 8'h00; hdma_init_req = 1'b0; hdma_line_req = 1'b0; xfer_done = 1'b0;
    tick(2);
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (cpu_halt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halt: got %b want 0", cpu_halt); end
    n_vec++; if (xfer_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b want 0", xfer_start); end
    n_vec++; if (xfer_ch !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_ch: got %0d want 0", xfer_ch); end
    n_vec++; if (xfer_kind !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_kind: got %b want 00", xfer_kind); end
    n_vec++; if (gdma_pending !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_pending: got %h want 00", gdma_pending); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_gdma_basic();
    bit found; xfer_t got, want; int cnt;
    logic [7:0] pend_after [2];
    pend_after[0] = 8'h04; pend_after[1] = 8'h00;
    gdma_we = 1'b1; gdma_mask = 8'h05;
    exp_q.push_back('{3'd0, 2'b00}); exp_q.push_back('{3'd2, 2'b00});
    tick();
    gdma_we = 1'b0; gdma_mask = 8'h00;
    n_vec++; if (gdma_pending !== 8'h05) begin n_fail++; $display("[TB] FAIL gdma_latch: got %h want 05", gdma_pending); end
    n_vec++; if (cpu_halt !== 1'b0) begin n_fail++; $display("[TB] FAIL gdma_no_boundary: halt %b want 0", cpu_halt); end
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    n_vec++; if (cpu_halt !== 1'b1) begin n_fail++; $display("[TB] FAIL gdma_halt_rise: got %b want 1", cpu_halt); end
    for (int i = 0; i < 2; i++) begin
      next_xfer(found, got); want = pop_exp();
      n_vec++;
      if (!found || got !== want) begin
        n_fail++;
        $display("[TB] FAIL gdma_xfer%0d: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", i, got.ch, got.kind, found, want.ch, want.kind);
      end
      n_vec++; if (cpu_halt !== 1'b1) begin n_fail++; $display("[TB] FAIL gdma_halt_hold%0d: got %b want 1", i, cpu_halt); end
      pulse_done(2);
      n_vec++;
      if (gdma_pending !== pend_after[i]) begin n_fail++; $display("[TB] FAIL gdma_pend%0d: got %h want %h", i, gdma_pending, pend_after[i]); end
    end
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    n_vec++; if (cnt !== 2) begin n_fail++; $display("[TB] FAIL gdma_resume_len: busy cycles %0d want 2", cnt); end
    n_vec++; if (cpu_halt !== 1'b0) begin n_fail++; $display("[TB] FAIL gdma_halt_fall: got %b want 0", cpu_halt); end
    tick();
  endtask

  task automatic test_hdma_line();
    bit found; xfer_t got, want; int extra;
    hdma_en = 8'h82; hdma_alive = 8'h02; hdma_line_req = 1'b1;
    exp_q.push_back('{3'd1, 2'b10});
    tick();
    hdma_line_req = 1'b0; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    next_xfer(found, got); want = pop_exp();
    n_vec++;
    if (!found || got !== want) begin
      n_fail++;
      $display("[TB] FAIL line_xfer: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", got.ch, got.kind, found, want.ch, want.kind);
    end
    pulse_done(1);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (xfer_start) extra++;
      if (!busy) break;
    end
    n_vec++; if (extra !== 0) begin n_fail++; $display("[TB] FAIL line_skip_ch7: extra starts %0d want 0", extra); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL line_idle: busy %b want 0", busy); end
    hdma_en = 8'h00; hdma_alive = 8'h00;
    tick();
  endtask

  task automatic test_preempt();
    bit found; xfer_t got, want;
    gdma_we = 1'b1; gdma_mask = 8'h18;
    exp_q.push_back('{3'd3, 2'b00});
    tick();
    gdma_we = 1'b0; gdma_mask = 8'h00; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    next_xfer(found, got); want = pop_exp();
    n_vec++;
    if (!found || got !== want) begin
      n_fail++;
      $display("[TB] FAIL preempt_first: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", got.ch, got.kind, found, want.ch, want.kind);
    end
    tick();
    hdma_en = 8'h01; hdma_init_req = 1'b1;
    exp_q.push_back('{3'd0, 2'b01}); exp_q.push_back('{3'd4, 2'b00});
    tick();
    hdma_init_req = 1'b0;
    n_vec++;
    if ({xfer_ch, xfer_kind, xfer_start} !== {3'd3, 2'b00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL preempt_hold: got ch=%0d kind=%b start=%b want ch=3 kind=00 start=0", xfer_ch, xfer_kind, xfer_start);
    end
    pulse_done(1);
    for (int i = 0; i < 2; i++) begin
      next_xfer(found, got); want = pop_exp();
      n_vec++;
      if (!found || got !== want) begin
        n_fail++;
        $display("[TB] FAIL preempt_xfer%0d: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", i, got.ch, got.kind, found, want.ch, want.kind);
      end
      pulse_done(1);
    end
    wait_idle();
    n_vec++; if ({busy, gdma_pending} !== 9'h000) begin n_fail++; $display("[TB] FAIL preempt_end: busy=%b pend=%h want 0/00", busy, gdma_pending); end
    hdma_en = 8'h00;
    tick();
  endtask

  task automatic test_cpu_en_low();
    bit found, quiet; xfer_t got, want;
    cpu_en = 1'b0; gdma_we = 1'b1; gdma_mask = 8'h40; cpu_boundary = 1'b1;
    exp_q.push_back('{3'd6, 2'b00});
    tick();
    gdma_we = 1'b0; gdma_mask = 8'h00;
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || cpu_halt || xfer_start) quiet = 1'b0;
    end
    n_vec++; if (quiet !== 1'b1) begin n_fail++; $display("[TB] FAIL en_low_frozen: activity %b want none", quiet); end
    n_vec++; if (gdma_pending !== 8'h40) begin n_fail++; $display("[TB] FAIL en_low_latch: got %h want 40", gdma_pending); end
    tick();
    cpu_en = 1'b1;
    next_xfer(found, got); want = pop_exp();
    cpu_boundary = 1'b0;
    n_vec++;
    if (!found || got !== want) begin
      n_fail++;
      $display("[TB] FAIL en_high_xfer: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", got.ch, got.kind, found, want.ch, want.kind);
    end
    pulse_done(1);
    wait_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    bit found; xfer_t got, want; int starts;
    gdma_we = 1'b1; gdma_mask = 8'h02;
    exp_q.push_back('{3'd1, 2'b00});
    tick();
    gdma_we = 1'b0; gdma_mask = 8'h00; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    next_xfer(found, got); want = pop_exp();
    n_vec++;
    if (!found || got !== want) begin
      n_fail++;
      $display("[TB] FAIL rstmid_xfer: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", got.ch, got.kind, found, want.ch, want.kind);
    end
    tick();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, cpu_halt, xfer_start} !== 3'b000) begin n_fail++; $display("[TB] FAIL rstmid_ctrl: busy/halt/start=%b want 000", {busy, cpu_halt, xfer_start}); end
    n_vec++;
    if ({xfer_ch, xfer_kind, gdma_pending} !== 13'h0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_data: ch=%0d kind=%b pend=%h want 0/00/00", xfer_ch, xfer_kind, gdma_pending);
    end
    tick();
    reset = 1'b0;
    tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    starts = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (xfer_start || busy) starts++;
    end
    n_vec++; if (starts !== 0) begin n_fail++; $display("[TB] FAIL rstmid_stray_done: active cycles %0d want 0", starts); end
    tick();
  endtask

  task automatic test_set_wins();
    bit found; xfer_t got, want;
    gdma_we = 1'b1; gdma_mask = 8'h01;
    exp_q.push_back('{3'd0, 2'b00}); exp_q.push_back('{3'd0, 2'b00});
    tick();
    gdma_we = 1'b0; gdma_mask = 8'h00; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_xfer(found, got); want = pop_exp();
      n_vec++;
      if (!found || got !== want) begin
        n_fail++;
        $display("[TB] FAIL setwin_xfer%0d: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", i, got.ch, got.kind, found, want.ch, want.kind);
      end
      if (i == 0) begin
        tick();
        xfer_done = 1'b1; gdma_we = 1'b1; gdma_mask = 8'h01;
        tick();
        xfer_done = 1'b0; gdma_we = 1'b0; gdma_mask = 8'h00;
        n_vec++; if (gdma_pending !== 8'h01) begin n_fail++; $display("[TB] FAIL setwin_pend: got %h want 01", gdma_pending); end
      end else begin
        pulse_done(1);
      end
    end
    wait_idle();
    n_vec++; if (gdma_pending !== 8'h00) begin n_fail++; $display("[TB] FAIL setwin_clear: got %h want 00", gdma_pending); end
    tick();
  endtask

  task automatic test_line_rearm();
    bit found; xfer_t got, want;
    hdma_en = 8'h03; hdma_alive = 8'h03; hdma_line_req = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back('{3'd0, 2'b10}); exp_q.push_back('{3'd1, 2'b10});
    end
    tick();
    hdma_line_req = 1'b0; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_xfer(found, got); want = pop_exp();
      n_vec++;
      if (!found || got !== want) begin
        n_fail++;
        $display("[TB] FAIL rearm_xfer%0d: got ch=%0d kind=%b start=%0b want ch=%0d kind=%b", i, got.ch, got.kind, found, want.ch, want.kind);
      end
      if (i == 0) begin
        tick();
        hdma_line_req = 1'b1;
        tick();
        hdma_line_req = 1'b0;
      end
      pulse_done(1);
    end
    wait_idle();
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rearm_idle: busy %b want 0", busy); end
    hdma_en = 8'h00; hdma_alive = 8'h00;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_gdma_basic();
    test_hdma_line();
    test_preempt();
    test_cpu_en_low();
    test_reset_mid();
    test_set_wins();
    test_line_rearm();
    n_vec++;
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL scoreboard_leftover: %0d queued want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_scheduler.md
DMA_SCHEDULER -- requirements
Module: dma_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: system clock, single domain.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port cpu_en, input, 1: CPU cycle enable; all state advances only when cpu_en=1, except reset.
REQ-004 SHALL have port cpu_boundary, input, 1: high while the CPU is in its opcode-fetch state (instruction boundary).
REQ-005 SHALL have ports gdma_we (input, 1) and gdma_mask (input, 8): MDMAEN write strobe and its data.
REQ-006 SHALL have port hdma_en, input, 8: HDMAEN register contents.
REQ-007 SHALL have ports hdma_init_req and hdma_line_req, input, 1 each: single-cycle pulses for frame start and hblank.
REQ-008 SHALL have port hdma_alive, input, 8: per-channel HDMA not-terminated flags from the channel datapath.
REQ-009 SHALL have port xfer_start, output, 1: one-cycle pulse requesting a channel transfer.
REQ-010 SHALL have port xfer_ch, output, 3: channel index, valid while busy.
REQ-011 SHALL have port xfer_kind, output, 2: 00 GDMA, 01 HDMA init, 10 HDMA line.
REQ-012 SHALL have port xfer_done, input, 1: channel datapath completion pulse.
REQ-013 SHALL have ports cpu_halt (output, 1), gdma_pending (output, 8) and busy (output, 1).

Function
REQ-014 SHALL latch request flags: gdma_pending |= gdma_mask on gdma_we; init_flag set on hdma_init_req; line_flag set on hdma_line_req. Latching occurs regardless of cpu_en.
REQ-015 SHALL implement states S_IDLE, S_SCHED, S_ISSUE, S_WAIT, S_RESUME.
REQ-016 S_IDLE->S_SCHED SHALL occur on cpu_en & cpu_boundary with any flag or pending bit set; cpu_halt SHALL rise in the same cycle the state becomes S_SCHED.
REQ-017 S_SCHED priority SHALL be: init_flag, then line_flag, then GDMA.
  - Within a kind: lowest channel index first.
  - HDMA candidates: init = hdma_en; line = hdma_en & hdma_alive.
  - GDMA candidates: gdma_pending & ~hdma_en.
REQ-018 When a kind has no candidates, S_SCHED SHALL clear that kind's flag and re-evaluate on the next enabled cycle. When nothing remains, S_SCHED SHALL go to S_RESUME.
REQ-019 S_ISSUE SHALL assert xfer_start for exactly one cpu_en-qualified cycle with stable xfer_ch and xfer_kind, then go to S_WAIT.
REQ-020 S_WAIT SHALL hold xfer_ch and xfer_kind until xfer_done, then:
  - GDMA: clear that gdma_pending bit.
  - HDMA: mark the channel serviced for the current pass.
  - Clear init_flag or line_flag once all candidates of that pass are serviced.
  - Return to S_SCHED.
REQ-021 HDMA SHALL preempt GDMA only between channel transfers, never inside S_WAIT.
REQ-022 S_RESUME SHALL last one enabled cycle; cpu_halt SHALL fall on entry to S_IDLE.
REQ-023 busy SHALL be 1 in every state except S_IDLE.
REQ-024 Simultaneous gdma_we setting a bit and xfer_done clearing the same bit: set SHALL win.
REQ-025 hdma_init_req SHALL clear line_flag and the serviced mask and restart the HDMA pass.
REQ-026 hdma_line_req during an active line pass SHALL re-set line_flag; a second pass SHALL follow.
REQ-027 xfer_done outside S_WAIT SHALL be ignored.
REQ-028 hdma_en changes mid-pass SHALL take effect at the next S_SCHED evaluation.

Reset
REQ-029 Reset SHALL force the following, immediately and asynchronously, including mid-transfer:
  - state S_IDLE, all flags and the serviced mask 0;
  - gdma_pending=0, cpu_halt=0, busy=0, xfer_start=0, xfer_ch=0, xfer_kind=00.

Structure
REQ-030 The state enum and the xfer_kind enum SHALL live in shared package dma_pkg.
REQ-031 The lowest-index 8-bit priority encoder SHALL be sub-module dma_prio_enc (outputs valid and index).

Verification
REQ-032 gdma_we mask=0x05 while idle, then boundary -> xfer_start on ch0, then ch2 (kind 00); gdma_pending 0x05->0x04->0x00; cpu_halt high throughout; one S_RESUME cycle.
REQ-033 hdma_en=0x82, hdma_alive=0x02, hdma_line_req -> only ch1 issued, kind 10; ch7 skipped.
REQ-034 GDMA ch3 in S_WAIT plus hdma_init_req with hdma_en=0x01 -> ch3 completes, ch0 kind 01 is issued next, then GDMA resumes.
REQ-035 cpu_en held low with a pending request -> no state change, no xfer_start, cpu_halt stays 0.
REQ-036 Reset asserted during S_WAIT -> all outputs 0 at once; a later xfer_done is ignored.
REQ-037 gdma_we mask=0x01 coincident with xfer_done for ch0 -> gdma_pending bit0 stays 1 and ch0 is re-issued.
